// File: rtl/xbar_bridge_slave_arbiter_if.sv
// Request/grant/response bundle between the bridge masters and one slave-port arbiter.
// The slave modport is the arbiter's view; the master modport is the driving side.
interface xbar_bridge_slave_arbiter_if #(
    parameter int N_REQ     = 9,
    parameter int ID_WIDTH  = N_REQ,
    parameter int CNT_WIDTH = 3,
    parameter int SEL_WIDTH = $clog2(N_REQ)
);
    logic [N_REQ-1:0]     req_i;
    logic [N_REQ-1:0]     gnt_o;
    logic                 slave_req_o;
    logic                 slave_gnt_i;
    logic [ID_WIDTH-1:0]  slave_ID_o;
    logic [SEL_WIDTH-1:0] sel_o;
    logic                 r_valid_i;
    logic [ID_WIDTH-1:0]  r_ID_i;
    logic [N_REQ-1:0]     r_valid_o;
    logic [CNT_WIDTH-1:0] outstanding_o;
    logic                 full_o;
    logic                 underflow_o;

    // Handshake: a transaction is accepted in any cycle where slave_req_o and
    // slave_gnt_i are both high; gnt_o names the master that won that cycle.
    modport slave (
        input  req_i, slave_gnt_i, r_valid_i, r_ID_i,
        output gnt_o, slave_req_o, slave_ID_o, sel_o, r_valid_o,
               outstanding_o, full_o, underflow_o
    );

    modport master (
        output req_i, slave_gnt_i, r_valid_i, r_ID_i,
        input  gnt_o, slave_req_o, slave_ID_o, sel_o, r_valid_o,
               outstanding_o, full_o, underflow_o
    );
endinterface

// File: rtl/xbar_bridge_slave_arbiter.sv
// Round-robin per-slave scheduler with grant hold, credit limit and one-hot response routing.
// Define XBAR_BRIDGE_ARB_PERF_EN to add the saturating stall/credit-block performance counters.
module xbar_bridge_slave_arbiter #(
    parameter int N_REQ           = 9,
    parameter int ID_WIDTH        = N_REQ,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    xbar_bridge_slave_arbiter_if.slave  bus,
    output logic                        dbg_state_o
`ifdef XBAR_BRIDGE_ARB_PERF_EN
    ,
    output logic [31:0]                 stall_cnt_o,
    output logic [31:0]                 credit_block_cnt_o
`endif
);
    localparam int SEL_W = $clog2(N_REQ);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT_GNT = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]     hold_q, hold_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 underflow_q, underflow_d;

    logic                 found;
    logic [SEL_W-1:0]     win, idx;
    logic                 full;
    logic                 sreq;
    logic                 accept;
    logic [N_REQ-1:0]     gnt;
    logic [SEL_W-1:0]     sel;
    logic [ID_WIDTH-1:0]  sid;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    assign full = (cnt_q == CNT_WIDTH'(MAX_OUTSTANDING));

    // First requester at or after rr_ptr, wrapping past the last master.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = SEL_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!found && bus.req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        sreq     = 1'b0;
        gnt      = '0;
        sel      = '0;
        sid      = '0;
        case (state_q)
            IDLE: begin
                if (found && !full) begin
                    sreq = 1'b1;
                    sel  = win;
                    sid  = ID_WIDTH'(1) << win;
                    if (bus.slave_gnt_i) begin
                        gnt[win] = 1'b1;
                        rr_ptr_d = wrap_inc(win);
                    end else begin
                        hold_d  = win;
                        state_d = WAIT_GNT;
                    end
                end
            end
            WAIT_GNT: begin
                // The held winner stays on sel/ID even if its master withdraws.
                sel  = hold_q;
                sid  = ID_WIDTH'(1) << hold_q;
                sreq = bus.req_i[hold_q];
                if (!bus.req_i[hold_q]) begin
                    state_d = IDLE;
                end else if (bus.slave_gnt_i) begin
                    gnt[hold_q] = 1'b1;
                    rr_ptr_d    = wrap_inc(hold_q);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = sreq & bus.slave_gnt_i;

    always_comb begin
        cnt_d       = cnt_q;
        underflow_d = underflow_q;
        if (bus.r_valid_i && cnt_q == '0) underflow_d = 1'b1;
        if (accept && !bus.r_valid_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && bus.r_valid_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    // Everything except response routing is forced quiet while reset is held.
    assign bus.slave_req_o   = rst_n & sreq;
    assign bus.gnt_o         = rst_n ? gnt : '0;
    assign bus.slave_ID_o    = rst_n ? sid : '0;
    assign bus.sel_o         = rst_n ? sel : '0;
    assign bus.outstanding_o = rst_n ? cnt_q : '0;
    assign bus.full_o        = rst_n & full;
    assign bus.underflow_o   = rst_n & underflow_q;
    assign bus.r_valid_o     = bus.r_ID_i & {N_REQ{bus.r_valid_i}};
    assign dbg_state_o       = (state_q == WAIT_GNT);

`ifdef XBAR_BRIDGE_ARB_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] cblk_q, cblk_d;

    always_comb begin
        stall_d = stall_q;
        cblk_d  = cblk_q;
        if (sreq && !bus.slave_gnt_i && stall_q != '1) stall_d = stall_q + 32'd1;
        if (|bus.req_i && full && cblk_q != '1)        cblk_d  = cblk_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            cblk_q  <= '0;
        end else begin
            stall_q <= stall_d;
            cblk_q  <= cblk_d;
        end
    end

    assign stall_cnt_o        = stall_q;
    assign credit_block_cnt_o = cblk_q;
`endif
endmodule

// File: tb/tb_xbar_bridge_slave_arbiter.sv
// Bench for xbar_bridge_slave_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_xbar_bridge_slave_arbiter;
    localparam int N_REQ   = 9;
    localparam int MAX_OUT = 4;
    localparam int CW      = 3;
    localparam int SW      = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic dbg_state;
    always #5 clk = ~clk;

    xbar_bridge_slave_arbiter_if #(
        .N_REQ(N_REQ), .ID_WIDTH(N_REQ), .CNT_WIDTH(CW), .SEL_WIDTH(SW)
    ) bus ();

`ifdef XBAR_BRIDGE_ARB_PERF_EN
    logic [31:0] stall_cnt, cblk_cnt;
`endif

    xbar_bridge_slave_arbiter #(
        .N_REQ(N_REQ), .ID_WIDTH(N_REQ), .MAX_OUTSTANDING(MAX_OUT), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .dbg_state_o(dbg_state)
`ifdef XBAR_BRIDGE_ARB_PERF_EN
        ,
        .stall_cnt_o(stall_cnt),
        .credit_block_cnt_o(cblk_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: plain integers describing the scheduler's visible rules.
    int     m_ptr    = 0;
    bit     m_hold_v = 1'b0;
    int     m_hold   = 0;
    int     m_out    = 0;
    bit     m_uf     = 1'b0;
    longint m_stall  = 0;
    longint m_cblk   = 0;
    int     pend_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N_REQ-1:0] r, input int ptr);
        logic [2*N_REQ-1:0] dbl;
        dbl = {r, r} >> ptr;
        for (int i = 0; i < N_REQ; i++) if (dbl[i]) return (ptr + i) % N_REQ;
        return -1;
    endfunction

    // Compare process: checks outputs mid-cycle, then advances the model across the next edge.
    initial begin
        forever begin
            logic [N_REQ-1:0] e_gnt, e_id, e_rv, req;
            logic             e_sreq, sg, rv;
            bit               full, accept, show;
            int               w;
            @(negedge clk);
            #2;
            req  = bus.req_i;
            sg   = bus.slave_gnt_i;
            rv   = bus.r_valid_i;
            e_rv = rv ? bus.r_ID_i : '0;
            chk("r_valid_o", 64'(bus.r_valid_o), 64'(e_rv));
            if (!rst_n) begin
                chk("rst_slave_req", 64'(bus.slave_req_o), 64'd0);
                chk("rst_gnt", 64'(bus.gnt_o), 64'd0);
                chk("rst_id", 64'(bus.slave_ID_o), 64'd0);
                chk("rst_sel", 64'(bus.sel_o), 64'd0);
                chk("rst_outstanding", 64'(bus.outstanding_o), 64'd0);
                chk("rst_full", 64'(bus.full_o), 64'd0);
                chk("rst_underflow", 64'(bus.underflow_o), 64'd0);
                m_ptr = 0; m_hold_v = 0; m_out = 0; m_uf = 0; m_stall = 0; m_cblk = 0;
                pend_q.delete();
            end else begin
                full = (m_out == MAX_OUT);
                if (m_hold_v) begin
                    w      = m_hold;
                    e_sreq = req[w];
                end else begin
                    w      = pick(req, m_ptr);
                    e_sreq = (w >= 0) && !full;
                end
                show  = m_hold_v || e_sreq;
                e_gnt = (e_sreq && sg) ? (N_REQ'(1) << w) : '0;
                chk("slave_req", 64'(bus.slave_req_o), 64'(e_sreq));
                chk("gnt", 64'(bus.gnt_o), 64'(e_gnt));
                if (show) begin
                    e_id = N_REQ'(1) << w;
                    chk("sel", 64'(bus.sel_o), 64'(w));
                    chk("slave_id", 64'(bus.slave_ID_o), 64'(e_id));
                end
                chk("outstanding", 64'(bus.outstanding_o), 64'(m_out));
                chk("full", 64'(bus.full_o), 64'(full));
                chk("underflow", 64'(bus.underflow_o), 64'(m_uf));
`ifdef XBAR_BRIDGE_ARB_PERF_EN
                chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
                chk("credit_block_cnt", 64'(cblk_cnt), 64'(m_cblk));
                if (e_sreq && !sg && m_stall < 64'hFFFF_FFFF) m_stall++;
                if (|req && full && m_cblk < 64'hFFFF_FFFF) m_cblk++;
`endif
                accept = e_sreq && sg;
                if (rv && m_out == 0) m_uf = 1;
                if (accept && !rv) m_out++;
                else if (!accept && rv && m_out > 0) m_out--;
                if (accept) begin
                    m_ptr    = (w + 1) % N_REQ;
                    m_hold_v = 0;
                    pend_q.push_back(w);
                end else if (m_hold_v && !req[w]) begin
                    m_hold_v = 0;
                end else if (!m_hold_v && e_sreq) begin
                    m_hold_v = 1;
                    m_hold   = w;
                end
            end
        end
    end

    task automatic drive(input logic r, input logic [N_REQ-1:0] req, input logic sg,
                         input logic rv, input logic [N_REQ-1:0] rid);
        @(negedge clk);
        rst_n           = r;
        bus.req_i       = req;
        bus.slave_gnt_i = sg;
        bus.r_valid_i   = rv;
        bus.r_ID_i      = rid;
        #3;
    endtask

    initial begin
        logic [N_REQ-1:0] req, rid;
        logic             r, sg, rv;
        rst_n = 1'b0; bus.req_i = '0; bus.slave_gnt_i = 1'b0; bus.r_valid_i = 1'b0; bus.r_ID_i = '0;

        // Reset with active requests: nothing may be granted.
        drive(0, 9'h1FF, 1, 0, 0);
        drive(0, 9'h1FF, 1, 0, 0);
        chk("lit_reset_gnt", 64'(bus.gnt_o), 64'h0);
        chk("lit_reset_sreq", 64'(bus.slave_req_o), 64'h0);

        // Round-robin with one response per cycle.
        drive(1, 9'h1FF, 1, 0, 0);
        chk("lit_rr_gnt0", 64'(bus.gnt_o), 64'h001);
        chk("lit_rr_out0", 64'(bus.outstanding_o), 64'd0);
        for (int k = 1; k <= 9; k++) begin
            drive(1, 9'h1FF, 1, 1, N_REQ'(1) << ((k - 1) % 9));
            chk("lit_rr_gnt", 64'(bus.gnt_o), 64'(N_REQ'(1) << (k % 9)));
            chk("lit_rr_out", 64'(bus.outstanding_o), 64'd1);
        end
        drive(1, 0, 0, 1, 9'h001);
        drive(1, 0, 0, 0, 0);
        chk("lit_rr_drained", 64'(bus.outstanding_o), 64'd0);

        // Grant hold from a fresh pointer.
        drive(0, 9'h005, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 9'h005, 0, 0, 0);
            chk("lit_hold_sel", 64'(bus.sel_o), 64'd0);
            chk("lit_hold_id", 64'(bus.slave_ID_o), 64'h001);
            chk("lit_hold_gnt", 64'(bus.gnt_o), 64'h0);
        end
        drive(1, 9'h005, 1, 0, 0);
        chk("lit_hold_final_gnt", 64'(bus.gnt_o), 64'h001);
        chk("lit_hold_final_sel", 64'(bus.sel_o), 64'd0);
        drive(1, 9'h005, 1, 0, 0);
        chk("lit_hold_next", 64'(bus.gnt_o), 64'h004);

        // Simultaneous accept and response at two outstanding.
        drive(1, 9'h001, 1, 1, 9'h001);
        chk("lit_sim_out", 64'(bus.outstanding_o), 64'd2);
        chk("lit_sim_rvalid", 64'(bus.r_valid_o), 64'h001);
        chk("lit_sim_gnt", 64'(bus.gnt_o), 64'h001);
        drive(1, 0, 0, 0, 0);
        chk("lit_sim_out_after", 64'(bus.outstanding_o), 64'd2);
        drive(1, 0, 0, 1, 9'h004);
        drive(1, 0, 0, 1, 9'h001);
        drive(1, 0, 0, 0, 0);
        chk("lit_sim_drained", 64'(bus.outstanding_o), 64'd0);

        // Credit limit.
        for (int k = 0; k < 4; k++) begin
            drive(1, 9'h001, 1, 0, 0);
            chk("lit_credit_gnt", 64'(bus.gnt_o), 64'h001);
        end
        drive(1, 9'h001, 1, 0, 0);
        chk("lit_credit_full", 64'(bus.full_o), 64'd1);
        chk("lit_credit_blocked", 64'(bus.slave_req_o), 64'd0);
        drive(1, 9'h001, 1, 1, 9'h001);
        chk("lit_credit_same_cycle", 64'(bus.slave_req_o), 64'd0);
        drive(1, 9'h001, 1, 0, 0);
        chk("lit_credit_out3", 64'(bus.outstanding_o), 64'd3);
        chk("lit_credit_regrant", 64'(bus.gnt_o), 64'h001);
        for (int k = 0; k < 4; k++) drive(1, 0, 0, 1, 9'h001);
        drive(1, 0, 0, 0, 0);
        chk("lit_credit_drained", 64'(bus.outstanding_o), 64'd0);

        // Underflow is sticky.
        drive(1, 0, 0, 1, 9'h002);
        chk("lit_uf_rvalid", 64'(bus.r_valid_o), 64'h002);
        drive(1, 0, 0, 0, 0);
        chk("lit_uf_set", 64'(bus.underflow_o), 64'd1);
        drive(1, 0, 0, 0, 0);
        chk("lit_uf_sticky", 64'(bus.underflow_o), 64'd1);

        // Reset while waiting for a grant.
        drive(1, 9'h010, 0, 0, 0);
        drive(1, 9'h010, 0, 0, 0);
        chk("lit_wait_state", 64'(dbg_state), 64'd1);
        chk("lit_wait_sel", 64'(bus.sel_o), 64'd4);
        drive(0, 9'h010, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("lit_post_rst_state", 64'(dbg_state), 64'd0);
        chk("lit_post_rst_uf", 64'(bus.underflow_o), 64'd0);
        drive(1, 9'h1FF, 1, 0, 0);
        chk("lit_post_rst_ptr0", 64'(bus.gnt_o), 64'h001);
        drive(1, 0, 0, 1, 9'h001);

`ifdef XBAR_BRIDGE_ARB_PERF_EN
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) drive(1, 9'h010, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("lit_perf_stall", 64'(stall_cnt), 64'd5);
`endif

        // Randomized traffic; responses only for transactions the model saw accepted.
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 299) != 0);
            case ($urandom_range(0, 3))
                0:       req = '0;
                1:       req = N_REQ'($urandom);
                default: req = N_REQ'($urandom & $urandom & $urandom);
            endcase
            sg  = ($urandom_range(0, 2) != 0);
            rv  = 1'b0;
            rid = '0;
            if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                int j;
                j   = $urandom_range(0, pend_q.size() - 1);
                rid = N_REQ'(1) << pend_q[j];
                rv  = 1'b1;
                pend_q.delete(j);
            end
            drive(r, req, sg, rv, rid);
        end
        drive(1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/xbar_bridge_slave_arbiter.md
Name: xbar_bridge_slave_arbiter

Overview: Per-slave request scheduler for the crossbar bridge. It shares one memory-side slave port between N_REQ masters (CH0 masters first, then CH1) using round-robin arbitration, holds the chosen winner stable until the slave grants, and limits the number of in-flight transactions with a credit counter. It also routes slave responses back to masters by one-hot ID. One instance sits in front of each slave port of the bridge.

Parameters:
N_REQ, 9, number of masters (N_CH0+N_CH1)
ID_WIDTH, N_REQ, one-hot ID width; must equal N_REQ
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions (1..255)
CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), outstanding counter width

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
req_i  input  N_REQ  per-master request already decoded for this slave
gnt_o  output  N_REQ  per-master grant, one-hot or zero
slave_req_o  output  1  request to slave
slave_gnt_i  input  1  slave grant
slave_ID_o  output  ID_WIDTH  one-hot ID of current winner
sel_o  output  $clog2(N_REQ)  binary index of winner; mux select for add/wdata/be/aux
r_valid_i  input  1  slave response valid
r_ID_i  input  ID_WIDTH  response ID, one-hot
r_valid_o  output  N_REQ  response valid routed to masters
outstanding_o  output  CNT_WIDTH  in-flight transaction count
full_o  output  1  outstanding_o == MAX_OUTSTANDING
underflow_o  output  1  sticky error flag

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, rr_ptr=0, outstanding=0, underflow=0. While in reset: slave_req_o=0, gnt_o=0, slave_ID_o=0, sel_o=0, outstanding_o=0, full_o=0, underflow_o=0. r_valid_o is still gated by r_valid_i.
- Winner search: the first set bit of req_i at or after rr_ptr, wrapping from N_REQ-1 to 0. This logic is combinational.
- FSM state IDLE:
  - If the winner exists and full_o=0: slave_req_o=1 in the same cycle; slave_ID_o=1<<winner; sel_o=winner.
  - Handshake (slave_gnt_i=1 in the same cycle): gnt_o[winner]=1; rr_ptr <= (winner+1) mod N_REQ; stay in IDLE.
  - Request with no grant: latch the winner into hold_idx and go to WAIT_GNT.
- FSM state WAIT_GNT:
  - The winner is hold_idx regardless of other requests, so sel_o and slave_ID_o stay stable.
  - slave_req_o = req_i[hold_idx].
  - On slave_gnt_i with req_i[hold_idx]=1: gnt_o[hold_idx]=1; rr_ptr <= hold_idx+1 (wrapping); go to IDLE.
  - If the master drops req_i[hold_idx] (protocol violation, tolerated): slave_req_o=0 and return to IDLE next cycle. No grant is issued and rr_ptr is unchanged.
- Zero-latency path: the IDLE handshake has combinational req-to-gnt. There is no register in the request path.
- Credit counter: +1 on an accepted handshake (slave_req_o & slave_gnt_i); -1 on r_valid_i. If both occur in the same cycle, the count is unchanged.
- full_o gates new arbitration. While full_o=1, slave_req_o=0 and gnt_o=0. A response in the same cycle does not unblock that cycle; it unblocks the next cycle.
- WAIT_GNT is entered only while not full, so full cannot occur while in WAIT_GNT.
- Underflow: r_valid_i with outstanding=0 sets underflow_o (sticky until reset) and leaves the count at 0.
- Response routing: r_valid_o = r_ID_i & {N_REQ{r_valid_i}}, combinational. Responses are independent of the FSM and the credit state.
- Reset mid-operation (in WAIT_GNT, or with outstanding>0): everything clears. Any responses after reset cause underflow.

Optional Feature:
XBAR_BRIDGE_ARB_PERF_EN
- Defined: adds outputs stall_cnt_o[31:0] and credit_block_cnt_o[31:0].
  - stall_cnt_o counts cycles with slave_req_o=1 and slave_gnt_i=0.
  - credit_block_cnt_o counts cycles with |req_i=1 and full_o=1.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- Round-robin: N_REQ=9, MAX_OUTSTANDING=4, req_i=9'h1FF, slave_gnt_i=1, r_valid_i=1 every cycle with matching IDs -> gnt_o sequence 0x001,0x002,0x004,...,0x100,0x001; outstanding_o stays 1 after the first cycle.
- Grant hold: req_i=0x005, slave_gnt_i=0 for 3 cycles, then 1 -> sel_o=0 and slave_ID_o=0x001 stable for 4 cycles; gnt_o=0x001 on cycle 4; next winner is index 2.
- Credit limit: req_i=0x001, slave_gnt_i=1, no responses -> 4 grants, then full_o=1 and slave_req_o=0. One r_valid_i with r_ID_i=0x001 -> outstanding_o=3 and a grant the following cycle.
- Simultaneous accept and response at outstanding_o=2 -> outstanding_o stays 2. r_valid_o=r_ID_i in the same cycle.
- Underflow and reset: r_valid_i=1 with outstanding_o=0 -> underflow_o=1 sticky. rst_n=0 for one edge while in WAIT_GNT -> next cycle state is IDLE, all outputs 0, rr_ptr=0.
- Perf (macro on): slave_gnt_i held 0 for 5 cycles with req_i=0x010 -> stall_cnt_o=5.
